cache_miss_handler: RTL and testbench

Controller that sits between the CPU load/store port and the direct-mapped write-through, no-write-allocate cache.
- Serves read hits from the cache.
- On a read miss, fetches the whole line from backing memory and writes it into the cache through the cache's write port.
- Forwards every store to memory, and updates the cache copy only when the store hits.
- Processes one CPU request at a time; memory sees at most one outstanding transaction.

---
 rtl/cache_miss_handler_if.sv | 44 ++++
 rtl/cache_miss_handler.sv | 147 ++++++++++++++
 tb/tb_cache_miss_handler.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_miss_handler_if.sv
// CPU, cache and memory signals seen by the miss handler, grouped as one bundle.
// master = controller side, slave = CPU/cache/memory side.
interface cache_miss_handler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  cpu_req_valid;
  logic                  cpu_req_ready;
  logic                  cpu_req_we;
  logic [ADDR_WIDTH-1:0] cpu_req_addr;
  logic [DATA_WIDTH-1:0] cpu_req_wdata;
  logic                  cpu_resp_valid;
  logic [DATA_WIDTH-1:0] cpu_resp_rdata;
  logic [ADDR_WIDTH-1:0] cache_addr;
  logic                  cache_we;
  logic [DATA_WIDTH-1:0] cache_wdata;
  logic                  cache_hit;
  logic [DATA_WIDTH-1:0] cache_rdata;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_rdata;

  modport master (
    input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
    input  cache_hit, cache_rdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    output cache_addr, cache_we, cache_wdata,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );

  modport slave (
    output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
    output cache_hit, cache_rdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    input  cache_addr, cache_we, cache_wdata,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );
endinterface

// File: rtl/cache_miss_handler.sv
// Miss handler for a direct-mapped write-through, no-write-allocate cache:
// read hits from cache, read misses fill the whole line, stores always go to memory.
module cache_miss_handler #(
  parameter int LOG_NUM_LINES  = 2,
  parameter int LOG_NUM_BLOCKS = 1,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8
) (
  input logic clk,
  input logic rst,
  cache_miss_handler_if.master bus
);
  localparam int NUM_BLOCKS = 1 << LOG_NUM_BLOCKS;
  localparam int K_W        = (LOG_NUM_BLOCKS > 0) ? LOG_NUM_BLOCKS : 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(NUM_BLOCKS - 1);

  // Index plus block offset must fit inside the word address.
  if (LOG_NUM_LINES + LOG_NUM_BLOCKS > ADDR_WIDTH) begin : g_cfg_check
    $error("cache_miss_handler: LOG_NUM_LINES + LOG_NUM_BLOCKS exceeds ADDR_WIDTH");
  end

  typedef enum logic [2:0] {
    IDLE, LOOKUP, FILL_REQ, FILL_WAIT, WR_REQ, WR_WAIT, RESP
  } state_t;

  state_t                state;
  logic [K_W-1:0]        k;
  logic                  we_q;
  logic                  wr_hit;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] resp_word;

  logic [ADDR_WIDTH-1:0] line_base;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic                  offset_match;
  logic                  last_blk;

  assign line_base    = addr_q & ~OFF_MASK;
  assign fill_addr    = line_base + ADDR_WIDTH'(k);
  assign offset_match = (addr_q & OFF_MASK) == ADDR_WIDTH'(k);
  assign last_blk     = (k == K_W'(NUM_BLOCKS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      k                  <= '0;
      bus.cpu_req_ready  <= 1'b1;
      bus.cpu_resp_valid <= 1'b0;
      bus.cpu_resp_rdata <= '0;
      bus.cache_addr     <= '0;
      bus.cache_we       <= 1'b0;
      bus.cache_wdata    <= '0;
      bus.mem_req_valid  <= 1'b0;
      bus.mem_req_we     <= 1'b0;
      bus.mem_req_addr   <= '0;
      bus.mem_req_wdata  <= '0;
    end else begin
      // Single-cycle pulses drop back unless a state below re-arms them.
      bus.cache_we       <= 1'b0;
      bus.cpu_resp_valid <= 1'b0;
      bus.cpu_resp_rdata <= '0;
      case (state)
        IDLE: begin
          if (bus.cpu_req_valid) begin
            we_q              <= bus.cpu_req_we;
            addr_q            <= bus.cpu_req_addr;
            wdata_q           <= bus.cpu_req_wdata;
            bus.cache_addr    <= bus.cpu_req_addr;
            bus.cpu_req_ready <= 1'b0;
            state             <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (we_q) begin
            wr_hit            <= bus.cache_hit;
            bus.mem_req_valid <= 1'b1;
            bus.mem_req_we    <= 1'b1;
            bus.mem_req_addr  <= addr_q;
            bus.mem_req_wdata <= wdata_q;
            state             <= WR_REQ;
          end else if (bus.cache_hit) begin
            resp_word <= bus.cache_rdata;
            state     <= RESP;
          end else begin
            k                 <= '0;
            bus.mem_req_valid <= 1'b1;
            bus.mem_req_we    <= 1'b0;
            bus.mem_req_addr  <= line_base;
            bus.cache_addr    <= line_base;
            state             <= FILL_REQ;
          end
        end
        FILL_REQ: begin
          // Address catches up with k after the previous word's write pulse.
          bus.cache_addr <= fill_addr;
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            state             <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (bus.mem_resp_valid) begin
            bus.cache_we    <= 1'b1;
            bus.cache_wdata <= bus.mem_resp_rdata;
            if (offset_match) resp_word <= bus.mem_resp_rdata;
            if (last_blk) begin
              state <= RESP;
            end else begin
              k                 <= k + K_W'(1);
              bus.mem_req_valid <= 1'b1;
              bus.mem_req_addr  <= fill_addr + ADDR_WIDTH'(1);
              state             <= FILL_REQ;
            end
          end
        end
        WR_REQ: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            bus.mem_req_we    <= 1'b0;
            if (wr_hit) begin
              bus.cache_we    <= 1'b1;
              bus.cache_wdata <= wdata_q;
            end
            state <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (bus.mem_resp_valid) begin
            resp_word <= '0;
            state     <= RESP;
          end
        end
        RESP: begin
          bus.cpu_resp_valid <= 1'b1;
          bus.cpu_resp_rdata <= resp_word;
          bus.cpu_req_ready  <= 1'b1;
          state              <= IDLE;
        end
        default: begin
          bus.cpu_req_ready <= 1'b1;
          state             <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cache_miss_handler.sv
// Directed bench for cache_miss_handler: hits, line fills, stores, reset mid-fill, back-to-back loads.
module tb_cache_miss_handler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_miss_handler_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  cache_miss_handler #(
    .LOG_NUM_LINES(2), .LOG_NUM_BLOCKS(1), .DATA_WIDTH(32), .ADDR_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ready_delay = 0;
  int resp_lat    = 0;
  int stab_viol   = 0;

  logic        hs_flag = 1'b0;
  logic        hs_we   = 1'b0;
  logic [7:0]  hs_addr = '0;

  logic [7:0]  we_addr_q[$];
  logic [31:0] we_data_q[$];
  logic        mem_we_q[$];
  logic [7:0]  mem_addr_q[$];
  logic [31:0] mem_wdata_q[$];
  logic [31:0] resp_q[$];
  int          resp_cyc_q[$];
  int          acc_cyc_q[$];
  int          mresp_cyc_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    case (a)
      8'h04:   return 32'h0000_0011;
      8'h05:   return 32'h0000_0022;
      default: return 32'hA5A5_A500 | {24'h0, a};
    endcase
  endfunction

  task automatic clear_logs();
    we_addr_q.delete(); we_data_q.delete();
    mem_we_q.delete(); mem_addr_q.delete(); mem_wdata_q.delete();
    resp_q.delete(); resp_cyc_q.delete(); acc_cyc_q.delete(); mresp_cyc_q.delete();
    stab_viol = 0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Observer on the falling edge: records every handshake and pulse.
  initial begin : monitor
    logic       pv, phs, prst, pwe;
    logic [7:0] paddr;
    logic [31:0] pdata;
    pv = 1'b0; phs = 1'b0; prst = 1'b1; pwe = 1'b0; paddr = '0; pdata = '0;
    forever begin
      @(negedge clk);
      if (pv && !phs && !prst &&
          (!bus.mem_req_valid || bus.mem_req_addr != paddr ||
           bus.mem_req_we != pwe || bus.mem_req_wdata != pdata))
        stab_viol++;
      hs_flag = bus.mem_req_valid && bus.mem_req_ready;
      hs_we   = bus.mem_req_we;
      hs_addr = bus.mem_req_addr;
      if (hs_flag) begin
        mem_we_q.push_back(bus.mem_req_we);
        mem_addr_q.push_back(bus.mem_req_addr);
        mem_wdata_q.push_back(bus.mem_req_wdata);
      end
      if (bus.cache_we) begin
        we_addr_q.push_back(bus.cache_addr);
        we_data_q.push_back(bus.cache_wdata);
      end
      if (bus.cpu_resp_valid) begin
        resp_q.push_back(bus.cpu_resp_rdata);
        resp_cyc_q.push_back(cyc);
      end
      if (bus.cpu_req_valid && bus.cpu_req_ready) acc_cyc_q.push_back(cyc + 1);
      if (bus.mem_resp_valid) mresp_cyc_q.push_back(cyc);
      pv = bus.mem_req_valid; phs = hs_flag; prst = rst;
      pwe = bus.mem_req_we; paddr = bus.mem_req_addr; pdata = bus.mem_req_wdata;
    end
  end

  // Memory model: ready after ready_delay cycles, response resp_lat cycles after accept.
  initial begin : memory
    int         wait_cnt, rcnt;
    logic       busy, rwe;
    logic [7:0] raddr;
    wait_cnt = 0; rcnt = 0; busy = 1'b0; rwe = 1'b0; raddr = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_rdata = '0;
      if (busy) begin
        if (rcnt == 0) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_rdata = rwe ? 32'h0 : mem_word(raddr);
          busy = 1'b0;
        end else begin
          rcnt--;
        end
      end
      if (hs_flag) begin
        busy = 1'b1; rcnt = resp_lat; raddr = hs_addr; rwe = hs_we;
        bus.mem_req_ready = 1'b0; wait_cnt = 0;
      end else if (bus.mem_req_valid && !bus.mem_req_ready) begin
        if (wait_cnt >= ready_delay) bus.mem_req_ready = 1'b1;
        else wait_cnt++;
      end else if (!bus.mem_req_valid) begin
        bus.mem_req_ready = 1'b0; wait_cnt = 0;
      end
    end
  end

  task automatic send(input logic we, input logic [7:0] a, input logic [31:0] d);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.cpu_req_valid = 1'b1; bus.cpu_req_we = we;
    bus.cpu_req_addr = a; bus.cpu_req_wdata = d;
    @(negedge clk);
    while (!bus.cpu_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.cpu_req_valid = 1'b0; bus.cpu_req_we = 1'b0;
    bus.cpu_req_addr = '0; bus.cpu_req_wdata = '0;
  endtask

  task automatic wait_resp(input int target);
    int n;
    n = 0;
    while (resp_q.size() < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("resp_arrived", 64'(resp_q.size() >= target), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  initial begin : main
    int base;
    bus.cpu_req_valid = 1'b0; bus.cpu_req_we = 1'b0;
    bus.cpu_req_addr = '0; bus.cpu_req_wdata = '0;
    bus.cache_hit = 1'b0; bus.cache_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready",      64'(bus.cpu_req_ready),  64'd1);
    check("rst_resp_valid", 64'(bus.cpu_resp_valid), 64'd0);
    check("rst_resp_rdata", 64'(bus.cpu_resp_rdata), 64'd0);
    check("rst_cache_out",  64'({bus.cache_we, bus.cache_addr, bus.cache_wdata}), 64'd0);
    check("rst_mem_out",    64'({bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata}), 64'd0);

    // Load hit
    clear_logs();
    bus.cache_hit = 1'b1; bus.cache_rdata = 32'hDEAD_BEEF;
    send(1'b0, 8'h05, 32'h0);
    wait_resp(1);
    check("hit_resp_cnt",  64'(resp_q.size()), 64'd1);
    check("hit_rdata",     64'(resp_q[0]), 64'hDEAD_BEEF);
    check("hit_latency",   64'(resp_cyc_q[0] - acc_cyc_q[0]), 64'd2);
    check("hit_no_mem",    64'(mem_addr_q.size()), 64'd0);
    check("hit_no_cwe",    64'(we_addr_q.size()), 64'd0);

    // Load miss with slow memory accept
    clear_logs();
    bus.cache_hit = 1'b0; bus.cache_rdata = '0;
    ready_delay = 3; resp_lat = 1;
    send(1'b0, 8'h05, 32'h0);
    wait_resp(1);
    check("miss_mem_cnt",  64'(mem_addr_q.size()), 64'd2);
    check("miss_mem_a0",   64'({mem_we_q[0], mem_addr_q[0]}), 64'h004);
    check("miss_mem_a1",   64'({mem_we_q[1], mem_addr_q[1]}), 64'h005);
    check("miss_cwe_cnt",  64'(we_addr_q.size()), 64'd2);
    check("miss_cwe_0",    64'({we_addr_q[0], we_data_q[0]}), 64'h04_0000_0011);
    check("miss_cwe_1",    64'({we_addr_q[1], we_data_q[1]}), 64'h05_0000_0022);
    check("miss_rdata",    64'(resp_q[0]), 64'h22);
    check("miss_stable",   64'(stab_viol), 64'd0);

    // Store hit
    clear_logs();
    bus.cache_hit = 1'b1; ready_delay = 1; resp_lat = 2;
    send(1'b1, 8'h09, 32'h0000_CAFE);
    wait_resp(1);
    check("sth_mem_cnt",   64'(mem_addr_q.size()), 64'd1);
    check("sth_mem",       64'({mem_we_q[0], mem_addr_q[0], mem_wdata_q[0]}), 64'h1_09_0000_CAFE);
    check("sth_cwe_cnt",   64'(we_addr_q.size()), 64'd1);
    check("sth_cwe",       64'({we_addr_q[0], we_data_q[0]}), 64'h09_0000_CAFE);
    check("sth_after_ack", 64'(resp_cyc_q[0] > mresp_cyc_q[0]), 64'd1);
    check("sth_rdata",     64'(resp_q[0]), 64'd0);

    // Store miss: memory only
    clear_logs();
    bus.cache_hit = 1'b0; ready_delay = 0; resp_lat = 0;
    send(1'b1, 8'h09, 32'h0000_1234);
    wait_resp(1);
    check("stm_mem",       64'({mem_we_q[0], mem_addr_q[0], mem_wdata_q[0]}), 64'h1_09_0000_1234);
    check("stm_no_cwe",    64'(we_addr_q.size()), 64'd0);
    check("stm_resp",      64'({resp_q.size(), resp_q[0]}), 64'h1_0000_0000);

    // Reset while waiting for the second fill word
    clear_logs();
    bus.cache_hit = 1'b0; ready_delay = 0; resp_lat = 4;
    send(1'b0, 8'h05, 32'h0);
    base = 0;
    while (mem_addr_q.size() < 2 && base < 200) begin
      @(negedge clk);
      base++;
    end
    check("rst_mid_hs2",   64'(mem_addr_q.size()), 64'd2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_cwe1",  64'(we_addr_q.size()), 64'd1);
    check("rst_mid_ready", 64'(bus.cpu_req_ready), 64'd1);
    check("rst_mid_outs",  64'({bus.mem_req_valid, bus.mem_req_addr, bus.cache_we,
                                bus.cache_addr, bus.cpu_resp_valid}), 64'd0);
    repeat (12) @(negedge clk);
    check("rst_late_resp", 64'(mresp_cyc_q.size()), 64'd2);
    check("rst_late_cwe",  64'(we_addr_q.size()), 64'd1);
    check("rst_late_nocpu",64'(resp_q.size()), 64'd0);
    check("rst_late_idle", 64'(bus.cpu_req_ready), 64'd1);

    // Normal load miss after reset
    clear_logs();
    resp_lat = 0;
    send(1'b0, 8'h13, 32'h0);
    wait_resp(1);
    check("post_mem",      64'({mem_addr_q[0], mem_addr_q[1]}), 64'h1213);
    check("post_cwe_cnt",  64'(we_addr_q.size()), 64'd2);
    check("post_rdata",    64'(resp_q[0]), 64'hA5A5_A513);

    // Back-to-back load hits with valid held high for 12 edges
    clear_logs();
    bus.cache_hit = 1'b1; bus.cache_rdata = 32'h0000_0077;
    @(posedge clk); #1;
    bus.cpu_req_valid = 1'b1; bus.cpu_req_we = 1'b0; bus.cpu_req_addr = 8'h30;
    repeat (12) @(posedge clk);
    #1 bus.cpu_req_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("b2b_accepts",   64'(acc_cyc_q.size()), 64'd4);
    check("b2b_resps",     64'(resp_q.size()), 64'd4);
    for (int i = 1; i < acc_cyc_q.size(); i++)
      check("b2b_spacing", 64'(acc_cyc_q[i] - acc_cyc_q[i-1]), 64'd3);
    for (int i = 0; i < resp_q.size(); i++)
      check("b2b_rdata",   64'(resp_q[i]), 64'h77);
    check("b2b_no_mem",    64'(mem_addr_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule
